// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin arbiter that shares one combinational ALU among
// NUM_REQ requesters. It grants one requester, registers the operands, drives
// the ALU, then returns the result on a valid/ready response channel.
module alu_req_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int OP_W    = 2,
   localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   input  logic [NUM_REQ*OP_W-1:0]   req_op,
   output logic [DATA_W-1:0]         alu_a,
   output logic [DATA_W-1:0]         alu_b,
   output logic [OP_W-1:0]           alu_op,
   input  logic [DATA_W-1:0]         alu_y,
   input  logic                      alu_ovf,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_y,
   output logic                      rsp_ovf,
   output logic                      busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]        state_q,     state_d;
   logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;
   logic [ID_W-1:0]   id_q,        id_d;
   logic [DATA_W-1:0] a_q,         a_d;
   logic [DATA_W-1:0] b_q,         b_d;
   logic [OP_W-1:0]   op_q,        op_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]   rsp_id_q,    rsp_id_d;
   logic [DATA_W-1:0] rsp_y_q,     rsp_y_d;
   logic              rsp_ovf_q,   rsp_ovf_d;

   logic [DATA_W-1:0] a_arr  [NUM_REQ];
   logic [DATA_W-1:0] b_arr  [NUM_REQ];
   logic [OP_W-1:0]   op_arr [NUM_REQ];

   logic              hi_found, lo_found;
   logic [ID_W-1:0]   hi_idx, lo_idx;
   logic              any_valid;
   logic [ID_W-1:0]   winner;

   // Unpack the flat request buses so the winner can index them directly.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign a_arr[g]  = req_a[g*DATA_W +: DATA_W];
      assign b_arr[g]  = req_b[g*DATA_W +: DATA_W];
      assign op_arr[g] = req_op[g*OP_W +: OP_W];
   end

   // Round-robin pick: the lowest valid index at or above rr_ptr wins;
   // failing that, wrap to the lowest valid index overall.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (req_valid[j]) begin
            if (!lo_found) begin
               lo_found = 1'b1;
               lo_idx   = ID_W'(j);
            end
            if (!hi_found && (ID_W'(j) >= rr_ptr_q)) begin
               hi_found = 1'b1;
               hi_idx   = ID_W'(j);
            end
         end
      end
      any_valid = lo_found;
      winner    = hi_found ? hi_idx : lo_idx;
   end

   // Next-state logic for the IDLE -> EXEC -> RESP transaction sequence.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      id_d        = id_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_y_d     = rsp_y_q;
      rsp_ovf_d   = rsp_ovf_q;
      case (state_q)
         S_IDLE: begin
            if (any_valid) begin
               a_d      = a_arr[winner];
               b_d      = b_arr[winner];
               op_d     = op_arr[winner];
               id_d     = winner;
               rr_ptr_d = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
               state_d  = S_EXEC;
            end
         end
         S_EXEC: begin
            rsp_y_d     = alu_y;
            rsp_ovf_d   = alu_ovf;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset drops any in-flight transaction.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         id_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_y_q     <= '0;
         rsp_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         id_q        <= id_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_y_q     <= rsp_y_d;
         rsp_ovf_q   <= rsp_ovf_d;
      end
   end

   assign req_ready = (reset_n && (state_q == S_IDLE) && any_valid)
                      ? (NUM_REQ'(1) << winner) : '0;
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_op    = op_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_y     = rsp_y_q;
   assign rsp_ovf   = rsp_ovf_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Testbench for alu_req_arbiter: table-driven single transactions plus
// hand-written sequences for back-to-back grants, stalls and mid-op reset.
module tb_alu_req_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int OW = 2;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*DW-1:0]  req_a, req_b;
   logic [NR*OW-1:0]  req_op;
   logic [DW-1:0]     alu_a, alu_b, alu_y;
   logic [OW-1:0]     alu_op;
   logic              alu_ovf;
   logic              rsp_valid, rsp_ready, rsp_ovf, busy;
   logic [1:0]        rsp_id;
   logic [DW-1:0]     rsp_y;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_req_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .OP_W(OW)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_y(alu_y), .alu_ovf(alu_ovf),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_ovf(rsp_ovf),
      .busy(busy)
   );

   // External 8-bit ALU: 00 ADD, 01 SUB, 10 AND, 11 OR; ovf is signed overflow.
   always_comb begin
      alu_y   = '0;
      alu_ovf = 1'b0;
      case (alu_op)
         2'd0: begin
            alu_y   = alu_a + alu_b;
            alu_ovf = (alu_a[7] == alu_b[7]) && (alu_y[7] != alu_a[7]);
         end
         2'd1: begin
            alu_y   = alu_a - alu_b;
            alu_ovf = (alu_a[7] != alu_b[7]) && (alu_y[7] != alu_a[7]);
         end
         2'd2: alu_y = alu_a & alu_b;
         default: alu_y = alu_a | alu_b;
      endcase
   end

   typedef struct {
      logic [NR-1:0] mask;
      int            win;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [OW-1:0] op;
      logic [DW-1:0] y;
      logic          ovf;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full transaction with rsp_ready=1; the winner's slot carries v's
   // operands, every other slot carries junk that must never reach the ALU.
   task automatic run_vec(input vec_t v);
      logic [NR-1:0] oh;
      oh = NR'(1) << v.win;
      for (int i = 0; i < NR; i++) begin
         req_a[i*DW +: DW]  = 8'hA0 + 8'(i);
         req_b[i*DW +: DW]  = 8'h50 + 8'(i);
         req_op[i*OW +: OW] = 2'(i);
      end
      req_a[v.win*DW +: DW]  = v.a;
      req_b[v.win*DW +: DW]  = v.b;
      req_op[v.win*OW +: OW] = v.op;
      req_valid = v.mask;
      rsp_ready = 1'b1;
      #1;
      check("t0_req_ready", 32'(req_ready), 32'(oh));
      check("t0_busy", 32'(busy), 0);
      step();
      req_valid = '0;
      #1;
      check("t1_alu_a", 32'(alu_a), 32'(v.a));
      check("t1_alu_b", 32'(alu_b), 32'(v.b));
      check("t1_alu_op", 32'(alu_op), 32'(v.op));
      check("t1_busy", 32'(busy), 1);
      check("t1_rsp_valid", 32'(rsp_valid), 0);
      step();
      check("t2_rsp_valid", 32'(rsp_valid), 1);
      check("t2_rsp_id", 32'(rsp_id), 32'(v.win));
      check("t2_rsp_y", 32'(rsp_y), 32'(v.y));
      check("t2_rsp_ovf", 32'(rsp_ovf), 32'(v.ovf));
      step();
      check("t3_rsp_valid", 32'(rsp_valid), 0);
      check("t3_busy", 32'(busy), 0);
   endtask

   initial begin
      int order [5];
      order = '{0, 1, 2, 3, 0};

      // rr_ptr annotated before each entry (entry 0 starts at rr_ptr=1).
      vecs[0]  = '{4'b0100, 2, 8'h7F, 8'h01, 2'd0, 8'h80, 1'b1}; // rr1 -> 3
      vecs[1]  = '{4'b0010, 1, 8'h05, 8'h07, 2'd1, 8'hFE, 1'b0}; // rr3 -> 2
      vecs[2]  = '{4'b1010, 3, 8'hF0, 8'h0F, 2'd2, 8'h00, 1'b0}; // rr2 -> 0
      vecs[3]  = '{4'b1111, 0, 8'h80, 8'h01, 2'd1, 8'h7F, 1'b1}; // rr0 -> 1
      vecs[4]  = '{4'b1111, 1, 8'hC3, 8'h3C, 2'd3, 8'hFF, 1'b0}; // rr1 -> 2
      vecs[5]  = '{4'b1111, 2, 8'h40, 8'h40, 2'd0, 8'h80, 1'b1}; // rr2 -> 3
      vecs[6]  = '{4'b1111, 3, 8'hFF, 8'h01, 2'd0, 8'h00, 1'b0}; // rr3 -> 0
      vecs[7]  = '{4'b1111, 0, 8'h12, 8'h34, 2'd2, 8'h10, 1'b0}; // rr0 -> 1
      vecs[8]  = '{4'b1001, 3, 8'h0A, 8'h14, 2'd0, 8'h1E, 1'b0}; // rr1 -> 0
      vecs[9]  = '{4'b1000, 3, 8'h7F, 8'h80, 2'd1, 8'hFF, 1'b1}; // rr0 -> 0
      vecs[10] = '{4'b0001, 0, 8'h01, 8'h02, 2'd3, 8'h03, 1'b0}; // rr0 -> 1

      // Reset with every requester asking.
      reset_n   = 1'b0;
      req_valid = 4'hF;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      rsp_ready = 1'b0;
      repeat (3) step();
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_alu_a", 32'(alu_a), 0);
      check("rst_alu_b", 32'(alu_b), 0);
      check("rst_alu_op", 32'(alu_op), 0);
      check("rst_rsp_id", 32'(rsp_id), 0);
      check("rst_rsp_y", 32'(rsp_y), 0);

      // All requesters held valid: grants 0,1,2,3,0, one every 3 cycles.
      reset_n   = 1'b1;
      req_a     = {8'h04, 8'h03, 8'h02, 8'h01};
      req_b     = {8'h01, 8'h01, 8'h01, 8'h01};
      req_op    = '0;
      rsp_ready = 1'b1;
      for (int c = 0; c < 15; c++) begin
         #1;
         if (c % 3 == 0)
            check("rr_grant", 32'(req_ready), 32'(NR'(1) << order[c/3]));
         else
            check("rr_nogrant", 32'(req_ready), 0);
         if (c % 3 == 2) begin
            check("rr_rsp_valid", 32'(rsp_valid), 1);
            check("rr_rsp_id", 32'(rsp_id), 32'(order[c/3]));
            check("rr_rsp_y", 32'(rsp_y), 32'(order[c/3] + 2));
         end
         step();
      end
      req_valid = '0;

      for (int k = 0; k < 11; k++) run_vec(vecs[k]);

      // Stalled response: rr_ptr=1, only req 0 asks.
      req_a[0 +: DW]  = 8'h21;
      req_b[0 +: DW]  = 8'h21;
      req_op[0 +: OW] = 2'd0;
      req_a[DW +: DW] = 8'h11;
      req_b[DW +: DW] = 8'h22;
      req_op[OW +: OW] = 2'd3;
      req_valid = 4'b0001;
      rsp_ready = 1'b0;
      #1;
      check("stall_grant", 32'(req_ready), 32'b0001);
      step();
      req_valid = 4'hF;
      step();
      for (int c = 0; c < 5; c++) begin
         check("stall_rsp_valid", 32'(rsp_valid), 1);
         check("stall_rsp_y", 32'(rsp_y), 32'h42);
         check("stall_rsp_id", 32'(rsp_id), 0);
         check("stall_rsp_ovf", 32'(rsp_ovf), 0);
         check("stall_req_ready", 32'(req_ready), 0);
         check("stall_busy", 32'(busy), 1);
         step();
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      req_valid = 4'b0010;
      #1;
      check("release_rsp_valid", 32'(rsp_valid), 0);
      check("release_busy", 32'(busy), 0);
      check("release_grant", 32'(req_ready), 32'b0010);
      step();
      check("exec_req1_alu_a", 32'(alu_a), 32'h11);

      // Reset for one cycle while req 1 is in EXEC.
      reset_n   = 1'b0;
      req_valid = 4'b0101;
      #1;
      check("midrst_req_ready", 32'(req_ready), 0);
      step();
      reset_n = 1'b1;
      rsp_ready = 1'b1;
      #1;
      check("midrst_rsp_valid", 32'(rsp_valid), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_grant", 32'(req_ready), 32'b0001);
      step();
      req_valid = '0;
      check("midrst_alu_a", 32'(alu_a), 32'h21);
      step();
      check("midrst_rsp_id", 32'(rsp_id), 0);
      check("midrst_rsp_y", 32'(rsp_y), 32'h42);
      step();
      check("final_idle", 32'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Round-robin scheduler that shares one combinational 8-bit ALU among NUM_REQ requesters.
- Each requester presents operands and an opcode on a valid/ready handshake.
- The arbiter grants one requester, drives the shared ALU from registered operands, captures the result and overflow flag, and returns them with the requester ID on a valid/ready response channel.
- Sits between the requesting datapath units and the single alu instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..16; non-power-of-2 allowed).
- DATA_W, 8, operand/result width; must match the ALU.
- OP_W, 2, opcode width; must match the ALU select (00 ADD, 01 SUB, 10 AND, 11 OR).
- ID_W, max(1,$clog2(NUM_REQ)), derived localparam, not overridable.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant; at most one bit high.
- req_a  in  NUM_REQ*DATA_W  packed operand A; requester i at [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  packed operand B, same packing.
- req_op  in  NUM_REQ*OP_W  packed opcode; requester i at [i*OP_W +: OP_W].
- alu_a  out  DATA_W  to ALU A.
- alu_b  out  DATA_W  to ALU B.
- alu_op  out  OP_W  to ALU OP_SEL.
- alu_y  in  DATA_W  from ALU Y.
- alu_ovf  in  1  from ALU OVF.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_y  out  DATA_W  captured result.
- rsp_ovf  out  1  captured overflow.
- busy  out  1  high when FSM is not IDLE.

Behaviour:
- Reset (reset_n low at posedge):
  - state=IDLE, rr_ptr=0.
  - Operand regs, and therefore alu_a/alu_b/alu_op, are 0.
  - rsp_valid=0, rsp_id=0, rsp_y=0, rsp_ovf=0, busy=0.
  - req_ready is forced 0 combinationally while reset_n=0.
- FSM states:
  - IDLE:
    - If any req_valid bit is set, the winner is the first set bit scanning rr_ptr, rr_ptr+1, ... with wrap at NUM_REQ.
    - req_ready[winner]=1 combinationally in the same cycle; all other bits 0.
    - At the posedge, capture req_a/req_b/req_op of the winner into the operand regs and the winner index into id_reg.
    - rr_ptr <= (winner==NUM_REQ-1) ? 0 : winner+1; next state EXEC.
    - If no req_valid bit is set, remain in IDLE with req_ready=0.
  - EXEC:
    - alu_* are driven from the operand regs.
    - At the posedge: rsp_y<=alu_y, rsp_ovf<=alu_ovf, rsp_id<=id_reg, rsp_valid<=1; next state RESP.
  - RESP:
    - rsp_* are held stable while rsp_valid=1.
    - When rsp_valid&rsp_ready, rsp_valid<=0 at the posedge; next state IDLE.
    - Otherwise remain in RESP indefinitely.
- req_ready=0 in EXEC and RESP. Requesters hold valid and data stable until req_ready is seen; req_valid changes during EXEC/RESP are ignored.
- alu_* always reflect the operand regs, so they hold the last granted values in IDLE/RESP.
- Latency: handshake in cycle T0, EXEC in T1, rsp_valid high in T2. Minimum 3 cycles per operation (rsp_ready=1 at T2 leads to the next grant at T3).
- rsp_ready high in the first cycle of rsp_valid: response accepted that cycle.
- No arithmetic in this block; ALU result and flag pass through unmodified.
- Reset asserted in EXEC or RESP: transaction dropped, no response issued, rr_ptr=0; the requester must reissue.
- rr_ptr wraps at NUM_REQ, not 2^ID_W.

Test Plan:
1. reset_n=0 for 3 cycles with req_valid=4'hF -> req_ready=0, rsp_valid=0, busy=0, alu_a=alu_b=0, alu_op=0.
2. Only req 2 valid, a=8'h7F, b=8'h01, op=00, rsp_ready=1; ALU model returns 8'h80 with ovf=1 -> req_ready=4'b0100 at T0; alu_a=7F, alu_b=01, alu_op=00 at T1; at T2 rsp_valid=1, rsp_id=2, rsp_y=8'h80, rsp_ovf=1.
3. req_valid=4'hF held continuously, rsp_ready=1 -> grant order 0,1,2,3,0, one grant every 3 cycles, rsp_id follows the same order.
4. rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_y/rsp_id/rsp_ovf stable, req_ready=0, busy=1. Then rsp_ready=1 for one cycle -> rsp_valid=0 next cycle, next grant the cycle after.
5. Grant req 2 (rr_ptr becomes 3), then only req 1 valid -> req 1 granted. Then req 1 and req 3 valid (rr_ptr=2) -> req 3 granted first.
6. reset_n low for 1 cycle during EXEC of req 1 -> no rsp_valid, rr_ptr=0. After release with req 0 and req 2 valid -> req 0 granted.
